// File: rtl/array_width_reduce_stream_pkg.sv
// array_width_reduce_stream_pkg
//   Shared constants for the array width-reduction stream block.
//   DIN_W_DEF / DOUT_W_DEF / ARR_L_DEF / SH_W_DEF : default geometry.
//   CLAMP_DEF : largest useful right shift for the default widths.
//   SATCNT_W  : width of the saturated-element counter.
//   The counter is only built when ARRAY_REDUCE_SATCNT_EN is defined.
package array_width_reduce_stream_pkg;

  localparam int unsigned DIN_W_DEF  = 6;
  localparam int unsigned DOUT_W_DEF = 4;
  localparam int unsigned ARR_L_DEF  = 32;
  localparam int unsigned SH_W_DEF   = 2;
  localparam int unsigned CLAMP_DEF  = DIN_W_DEF - DOUT_W_DEF;
  localparam int unsigned SATCNT_W   = 32;

endpackage

// File: rtl/array_width_reduce_stream_if.sv
// array_width_reduce_stream_if
//   Stream bundle for array_width_reduce_stream.
//   Input side : in_valid, in_ready, in_data, shift, round_en
//   Output side: out_valid, out_ready, out_data, sat_any
//   slave  : the reducer's view (consumes the input beat, produces results)
//   master : the environment's view (drives beats, accepts results)
interface array_width_reduce_stream_if
  import array_width_reduce_stream_pkg::*;
#(
  parameter int unsigned DIN_W  = DIN_W_DEF,
  parameter int unsigned DOUT_W = DOUT_W_DEF,
  parameter int unsigned ARR_L  = ARR_L_DEF,
  parameter int unsigned SH_W   = SH_W_DEF
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [DIN_W*ARR_L-1:0]  in_data;
  logic [SH_W-1:0]         shift;
  logic                    round_en;
  logic                    out_valid;
  logic                    out_ready;
  logic [DOUT_W*ARR_L-1:0] out_data;
  logic                    sat_any;

  modport slave (
    input  in_valid, in_data, shift, round_en, out_ready,
    output in_ready, out_valid, out_data, sat_any
  );

  modport master (
    output in_valid, in_data, shift, round_en, out_ready,
    input  in_ready, out_valid, out_data, sat_any
  );

endinterface

// File: rtl/array_width_reduce_stream_ele_reduce.sv
// ele_reduce
//   Combinational single-element width reducer: right shift, optional
//   round-half-up, saturate to DOUT_W bits.
//   v_i   : DIN_W-bit unsigned element
//   sh_i  : shift amount, already clamped to DIN_W-DOUT_W by the caller
//   rnd_i : round-half-up enable
//   r_o   : DOUT_W-bit result (all ones when saturated)
//   sat_o : result saturated
module ele_reduce
  import array_width_reduce_stream_pkg::*;
#(
  parameter int unsigned DIN_W  = DIN_W_DEF,
  parameter int unsigned DOUT_W = DOUT_W_DEF,
  parameter int unsigned SH_W   = SH_W_DEF
) (
  input  logic [DIN_W-1:0]  v_i,
  input  logic [SH_W-1:0]   sh_i,
  input  logic              rnd_i,
  output logic [DOUT_W-1:0] r_o,
  output logic              sat_o
);

  logic [DIN_W:0] ext;
  logic [DIN_W:0] bias;
  logic [DIN_W:0] t;

  // Adding 2^(s-1) before the shift equals (v >> s) + bit(s-1) of v; the
  // extra MSB absorbs the carry so overflow is seen by the saturation test.
  always_comb begin
    ext  = {1'b0, v_i};
    bias = '0;
    if (rnd_i && (sh_i != '0)) begin
      bias = (DIN_W+1)'(1) << (sh_i - SH_W'(1));
    end
    t     = (ext + bias) >> sh_i;
    sat_o = |t[DIN_W:DOUT_W];
    r_o   = sat_o ? '1 : t[DOUT_W-1:0];
  end

endmodule

// File: rtl/array_width_reduce_stream.sv
// array_width_reduce_stream
//   Two-stage pipelined reducer of ARR_L DIN_W-bit elements to DOUT_W bits
//   per element with shift / round-half-up / saturation.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : stream bundle (slave modport), see array_width_reduce_stream_if
//   sat_clr  : synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt  : running count of saturated elements delivered downstream
//   Build option: define ARRAY_REDUCE_SATCNT_EN to build the counter;
//   otherwise sat_cnt reads 0 and sat_clr is ignored.
module array_width_reduce_stream
  import array_width_reduce_stream_pkg::*;
#(
  parameter int unsigned DIN_W  = DIN_W_DEF,
  parameter int unsigned DOUT_W = DOUT_W_DEF,
  parameter int unsigned ARR_L  = ARR_L_DEF,
  parameter int unsigned SH_W   = SH_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  array_width_reduce_stream_if.slave    bus,
  input  logic                          sat_clr,
  output logic [SATCNT_W-1:0]           sat_cnt
);

  localparam int unsigned      CLAMP   = DIN_W - DOUT_W;
  localparam logic [SH_W-1:0]  CLAMP_S = SH_W'(CLAMP);

  // Stage 1: raw beat plus clamped controls
  logic                    s1_valid_q, s1_valid_d;
  logic [DIN_W*ARR_L-1:0]  s1_data_q,  s1_data_d;
  logic [SH_W-1:0]         s1_sh_q,    s1_sh_d;
  logic                    s1_rnd_q,   s1_rnd_d;

  // Stage 2: reduced result
  logic                    s2_valid_q, s2_valid_d;
  logic [DOUT_W*ARR_L-1:0] s2_data_q,  s2_data_d;
  logic                    s2_sat_q,   s2_sat_d;

  logic [SH_W-1:0]         sh_clamped;
  logic [DOUT_W*ARR_L-1:0] red_data;
  logic [ARR_L-1:0]        red_sat;
  logic                    s2_adv;
  logic                    s1_load;

  assign sh_clamped = (bus.shift > CLAMP_S) ? CLAMP_S : bus.shift;

  // Stage 2 can take new contents when empty or being drained this cycle;
  // stage 1 likewise when empty or moving into stage 2.
  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s2_adv;
  assign s1_load      = bus.in_valid && bus.in_ready;

  for (genvar g = 0; g < ARR_L; g++) begin : g_ele
    ele_reduce #(
      .DIN_W (DIN_W),
      .DOUT_W(DOUT_W),
      .SH_W  (SH_W)
    ) u_ele (
      .v_i  (s1_data_q[DIN_W*g +: DIN_W]),
      .sh_i (s1_sh_q),
      .rnd_i(s1_rnd_q),
      .r_o  (red_data[DOUT_W*g +: DOUT_W]),
      .sat_o(red_sat[g])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_sh_d    = s1_sh_q;
    s1_rnd_d   = s1_rnd_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    if (bus.in_ready) begin
      s1_valid_d = bus.in_valid;
    end
    if (s1_load) begin
      s1_data_d = bus.in_data;
      s1_sh_d   = sh_clamped;
      s1_rnd_d  = bus.round_en;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = red_data;
        s2_sat_d  = |red_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_sh_q    <= '0;
      s1_rnd_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_sh_q    <= s1_sh_d;
      s1_rnd_q   <= s1_rnd_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.sat_any   = s2_sat_q;

`ifdef ARRAY_REDUCE_SATCNT_EN
  localparam int unsigned PC_W = $clog2(ARR_L + 1);

  logic [PC_W-1:0]     red_nsat;
  logic [PC_W-1:0]     s2_nsat_q, s2_nsat_d;
  logic [SATCNT_W:0]   cnt_sum;
  logic [SATCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    red_nsat = '0;
    for (int unsigned i = 0; i < ARR_L; i++) begin
      red_nsat = red_nsat + PC_W'(red_sat[i]);
    end
  end

  // Popcount travels with the beat so the count is added at output handshake.
  always_comb begin
    s2_nsat_d = s2_nsat_q;
    if (s2_adv && s1_valid_q) begin
      s2_nsat_d = red_nsat;
    end
    cnt_sum = {1'b0, cnt_q} + (SATCNT_W+1)'(s2_nsat_q);
    cnt_d   = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q && bus.out_ready) begin
      cnt_d = cnt_sum[SATCNT_W] ? '1 : cnt_sum[SATCNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_nsat_q <= '0;
      cnt_q     <= '0;
    end else begin
      s2_nsat_q <= s2_nsat_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sat_cnt = cnt_q;
`else
  logic unused_sat_clr;
  assign unused_sat_clr = sat_clr;
  assign sat_cnt        = '0;
`endif

endmodule

// File: doc/array_width_reduce_stream.md
ARRAY_WIDTH_REDUCE_STREAM -- requirements
Module: array_width_reduce_stream

Interface
REQ-001 Parameter DIN_W, default 6, input element width in bits (unsigned).
REQ-002 Parameter DOUT_W, default 4, output element width; SHALL satisfy DOUT_W < DIN_W.
REQ-003 Parameter ARR_L, default 32, element count per beat.
REQ-004 Parameter SH_W, default 2, width of shift port; SHALL be able to encode DIN_W-DOUT_W.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  beat offered.
REQ-008 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-009 in_data  input  DIN_W*ARR_L  element i at bits [DIN_W*i +: DIN_W].
REQ-010 shift  input  SH_W  right-shift amount, sampled with the accepted beat.
REQ-011 round_en  input  1  round-half-up enable, sampled with the accepted beat.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-014 out_data  output  DOUT_W*ARR_L  element i at bits [DOUT_W*i +: DOUT_W].
REQ-015 sat_any  output  1  at least one element of current out_data saturated.
REQ-016 sat_clr  input  1  synchronous clear of sat_cnt.
REQ-017 sat_cnt  output  32  saturated-element counter.

Function
REQ-018 Per element: s = min(shift, DIN_W-DOUT_W); t = v >> s; if round_en && s>0, t = t + bit (s-1) of v, computed in DIN_W+1 bits.
REQ-019 If t > 2^DOUT_W-1, output element SHALL be all ones (saturated); else low DOUT_W bits of t.
REQ-020 With shift=0 and round_en=0, output SHALL equal the legacy saturating truncation (any bit above DOUT_W set -> all ones).
REQ-021 Two-register pipeline: stage 1 captures in_data, clamped shift, round_en; stage 2 holds reduced result and sat_any.
REQ-022 Latency SHALL be exactly 2 cycles from input handshake to out_valid with no backpressure; throughput 1 beat/cycle.
REQ-023 Stage k SHALL load when empty or when its contents advance the same cycle; in_ready = !s1_valid || s1 advances (combinational from out_ready permitted).
REQ-024 While out_valid && !out_ready, out_data and sat_any SHALL hold stable; no beat lost, duplicated or reordered.
REQ-025 Simultaneous input and output handshake with both stages full SHALL sustain full throughput.
REQ-026 sat_cnt SHALL add the number of saturated elements of each beat at output handshake, saturating at 2^32-1.
REQ-027 sat_clr and an increment in the same cycle: clear wins, sat_cnt = 0.

Reset
REQ-028 On rst: both stage valids 0, out_valid 0, out_data 0, sat_any 0, sat_cnt 0; in_ready 1 on the first cycle after release.
REQ-029 rst asserted mid-stream SHALL discard all in-flight beats without emitting them.

Configuration
REQ-030 Macro ARRAY_REDUCE_SATCNT_EN defined: REQ-026/027 counter logic built.
REQ-031 Macro undefined: sat_cnt tied to 0, sat_clr ignored, no counter or popcount logic; sat_any and datapath unchanged.

Structure
REQ-032 Shared package holds default widths (DIN_W/DOUT_W/ARR_L), the clamp constant DIN_W-DOUT_W and the sat_cnt width constant (32).
REQ-033 One sub-module, ele_reduce: combinational single-element shift/round/saturate with a saturated flag, instanced ARR_L times in a generate loop.

Verification (DIN_W=6, DOUT_W=4, ARR_L=4, macro defined)
REQ-034 shift=0, round_en=0, elements {5,15,16,63} -> {5,15,15,15}, sat_any=1, out_valid 2 cycles after accept.
REQ-035 shift=2, round_en=1, elements {6,61,62,3} -> {2,15,15,1}, sat_any=1 (62 rounds to 16 and saturates); shift=3 yields same result (clamped).
REQ-036 out_ready low 5 cycles, 3 beats offered back-to-back -> exactly 2 accepted, in_ready low, out_data stable; on release all 3 emerge in order.
REQ-037 rst pulsed with 2 beats in flight -> out_valid 0, no beat emitted after release, sat_cnt 0.
REQ-038 Three beats with 1, 0, 4 saturated elements -> sat_cnt=5; sat_clr asserted on a cycle with a saturating handshake -> sat_cnt=0.
REQ-039 Continuous in_valid/out_ready for 100 random beats -> 100 outputs, 1/cycle, matching a software model.
